// File: rtl/rom_burst_reader_pkg.sv
// Shared definitions for the ROM burst reader and the ROM it drives.
// Both blocks take their default widths from here so they stay matched.
package rom_burst_reader_pkg;

  localparam int ROM_DATA_WIDTH = 8;
  localparam int ROM_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rom_burst_reader.sv
// Burst sequencer in front of a combinational ROM.
// A (base, length) command walks the ROM address upward, modulo the address
// space. Each word is captured into an output register and presented on a
// valid/ready stream, with m_last marking the final word.
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = ROM_DATA_WIDTH,
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;
  logic                  valid_reg, valid_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  last_reg, last_next;
  logic                  load;
  logic                  out_free;

  // The output register can take a new word when it is empty or its current
  // word is being accepted this cycle.
  assign out_free = !valid_reg || m_ready;

  // Next-state and datapath decisions; everything holds unless changed below.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    valid_next     = valid_reg;
    data_next      = data_reg;
    last_next      = last_reg;
    load           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_next      = base_addr;
            remaining_next = length;
            state_next     = STREAM;
          end else begin
            // Empty burst: nothing to emit, just report completion.
            state_next = DONE;
          end
        end
      end

      STREAM: begin
        load = (remaining_reg != '0) && out_free;
        if (load) begin
          data_next      = rom_data;
          valid_next     = 1'b1;
          last_next      = (remaining_reg == LEN_WIDTH'(1));
          addr_next      = addr_reg + ADDR_WIDTH'(1);
          remaining_next = remaining_reg - LEN_WIDTH'(1);
        end else if (valid_reg && m_ready) begin
          // Final word drained with nothing left to fetch.
          valid_next = 1'b0;
          last_next  = 1'b0;
        end

        if ((remaining_reg == '0) && out_free) begin
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      valid_reg     <= 1'b0;
      data_reg      <= '0;
      last_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      valid_reg     <= valid_next;
      data_reg      <= data_next;
      last_reg      <= last_next;
    end
  end

  assign rom_addr = addr_reg;
  assign m_valid  = valid_reg;
  assign m_data   = data_reg;
  assign m_last   = last_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);

endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
Sequencer that sits directly upstream of rom_simple. It accepts a burst command (base address, length) and drives the ROM address sequentially. It captures each combinational ROM word into an output register and streams the words downstream over a valid/ready handshake with a last marker. It gives the read-only store a streaming front end, so consumers never drive ROM addresses themselves.

Parameters:
DATA_WIDTH, 8, ROM word width; must match rom_simple DATA_WIDTH
ADDR_WIDTH, 8, ROM address width; must match rom_simple ADDR_WIDTH
LEN_WIDTH, ADDR_WIDTH+1, burst length width; allows a full-ROM burst of 2**ADDR_WIDTH words

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first ROM address of the burst
length  input  LEN_WIDTH  number of words to read; 0 = empty burst
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when the burst fully completes
rom_addr  output  ADDR_WIDTH  address to rom_simple.addr; driven from a register
rom_data  input  DATA_WIDTH  from rom_simple.data_out; combinational in rom_addr
m_valid  output  1  output word valid
m_ready  input  1  downstream accept
m_data  output  DATA_WIDTH  output word
m_last  output  1  qualifies the final word of the burst; meaningful only with m_valid

Behaviour:
- Reset (async on rst_n low, released synchronously to clk): state=IDLE, rom_addr=0, remaining=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
- State IDLE:
  - start=1 and length!=0: addr_q<=base_addr, remaining<=length, go to STREAM.
  - start=1 and length==0: go to DONE; no words are emitted.
- State STREAM:
  - Load condition: remaining!=0 and (m_valid==0 or m_ready==1).
  - On load: m_data<=rom_data (addressed by current rom_addr), m_valid<=1, m_last<=(remaining==1), addr_q<=addr_q+1, remaining<=remaining-1.
  - Accept without load: m_valid && m_ready with remaining==0 clears m_valid and m_last.
  - Exit: when remaining==0 and (m_valid==0, or m_valid && m_ready this cycle), go to DONE.
- State DONE: done=1 for exactly one cycle, then go to IDLE.
- Throughput and latency:
  - One word per cycle while m_ready is held high.
  - start at edge T leads to first m_valid after edge T+2.
  - After the last handshake, done is high in the following cycle.
- Backpressure: with m_valid && !m_ready, m_data, m_last and rom_addr hold stable. No word is dropped or duplicated.
- Address arithmetic: addr_q increments modulo 2**ADDR_WIDTH, so base 0xFE with length 4 reads FE, FF, 00, 01.
- remaining is LEN_WIDTH wide. length values above 2**ADDR_WIDTH are legal and re-read wrapped addresses.
- start outside IDLE is ignored; there is no queuing or abort.
- rom_addr holds its last value in IDLE and DONE.
- Reset mid-burst: all state returns to reset values immediately. A partially streamed burst is abandoned, and m_last is never asserted for it.

Decomposition:
- Shared package holds:
  - state enum (IDLE, STREAM, DONE)
  - default DATA_WIDTH/ADDR_WIDTH constants, shared with rom_simple so the two cannot drift
- No sub-module required. The output register plus valid logic can optionally be split as rom_stream_outreg (a one-entry skid register) if reused elsewhere.
- Bench instantiates rom_burst_reader feeding rom_simple, with the ROM preloaded as mem[i] = i ^ 8'hA5.

Test Plan:
- Burst, no backpressure: start, base=0x10, length=4, m_ready=1 → m_data 0xB5, 0xB4, 0xB7, 0xB6 on 4 consecutive cycles; m_last only on 0xB6; done one cycle later; busy low after.
- Address wrap: base=0xFE, length=4 → rom_addr sequence FE, FF, 00, 01; m_data 0x5B, 0x5A, 0xA5, 0xA4.
- Backpressure: base=0x00, length=3, m_ready low for 3 cycles after the first valid → m_data holds 0xA5 and rom_addr holds stable while stalled; full sequence 0xA5, 0xA4, 0xA7 with no loss or duplication.
- Empty burst and ignored start:
  - length=0 → m_valid never asserted; done pulses after exactly 2 cycles.
  - a second start during STREAM does not change addr_q or remaining.
- Reset mid-burst: length=8, assert rst_n low after 3 words accepted → m_valid, m_last, busy and done drop asynchronously; after release, a new burst base=0x20, length=1 yields 0x85 with m_last=1.
